// File: rtl/capture_sequencer_pkg.sv
// Shared command opcodes, FSM state encoding and window clamp helper
// for the frame capture sequencer.
package capture_sequencer_pkg;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_SNAP    = 2'd1;
    localparam logic [1:0] OP_STOP    = 2'd2;
    localparam logic [1:0] OP_SET_WIN = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    function automatic logic [15:0] clamp_u16(input logic [15:0] v, input logic [15:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/capture_sequencer_fval_edge.sv
// Registers the sensor frame-valid once and flags its rising/falling edges.
module fval_edge (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic fval_i,
    output logic rise_o,
    output logic fall_o
);

    logic pfval_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) pfval_q <= 1'b0;
        else         pfval_q <= fval_i;
    end

    assign rise_o = ~pfval_q &  fval_i;
    assign fall_o =  pfval_q & ~fval_i;

endmodule

// File: rtl/capture_sequencer.sv
// Frame capture sequencer: arms the capture datapath on frame boundaries,
// counts frames per SNAP, and aborts to IDLE on a frame-valid watchdog.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_X   = 640,
    parameter int unsigned MAX_Y   = 280,
    parameter int unsigned TIMEOUT = 2**24
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iFVAL,
    input  logic             iCMD_VALID,
    input  logic [1:0]       iCMD_OP,
    input  logic [15:0]      iCMD_X,
    input  logic [15:0]      iCMD_Y,
    input  logic [CNT_W-1:0] iCMD_N,
    output logic             oCMD_READY,
    output logic             oSTART,
    output logic             oEND,
    output logic [15:0]      oX_POS,
    output logic [15:0]      oY_POS,
    output logic [CNT_W-1:0] oFRAME_CNT,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oERR
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, n_q, n_d, cnt_inc;
    logic [15:0]      x_q, x_d, y_q, y_d;
    logic             start_q, start_d, end_q, end_d, done_q, done_d, err_q, err_d;
    logic             busy_q, ready_q;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             rise, fall, cmd_acc, stop_acc, wd_expire;

    fval_edge u_fval_edge (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .fval_i (iFVAL),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign cmd_acc   = iCMD_VALID && ready_q;
    assign stop_acc  = iCMD_VALID && (iCMD_OP == OP_STOP) && (state_q != ST_IDLE);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign wd_expire = (state_q != ST_IDLE) && !(rise || fall) && (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        x_d     = x_q;
        y_d     = y_q;
        start_d = 1'b0;
        end_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc && iCMD_OP == OP_SNAP) begin
                    n_d     = iCMD_N;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_SYNC;
                end else if (cmd_acc && iCMD_OP == OP_SET_WIN) begin
                    x_d = clamp_u16(iCMD_X, 16'(MAX_X));
                    y_d = clamp_u16(iCMD_Y, 16'(MAX_Y));
                end
            end
            ST_SYNC: begin
                if (stop_acc) begin
                    state_d = ST_IDLE;
                end else if (!iFVAL) begin
                    start_d = 1'b1;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED, ST_RUN: begin
                // A rise in the same cycle as STOP is counted first; STOP then
                // acts on whichever state the rise led to.
                if (rise) begin
                    cnt_d = cnt_inc;
                    if (state_q == ST_ARMED) begin
                        if (n_q == CNT_W'(1)) begin
                            end_d   = 1'b1;
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (n_q != '0 && cnt_inc == n_q) begin
                        end_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
                if (stop_acc && state_d == ST_ARMED) begin
                    end_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (stop_acc && state_d == ST_RUN) begin
                    end_d   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fall) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wd_expire) begin
            end_d   = (state_q == ST_ARMED) || (state_q == ST_RUN);
            start_d = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        if (state_d != state_q || rise || fall || state_q == ST_IDLE) wd_d = '0;
        else                                                          wd_d = wd_q + WD_W'(1);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            x_q     <= x_d;
            y_q     <= y_d;
            start_q <= start_d;
            end_q   <= end_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= (state_d != ST_IDLE);
            ready_q <= (state_d == ST_IDLE);
            wd_q    <= wd_d;
        end
    end

    assign oCMD_READY = ready_q;
    assign oSTART     = start_q;
    assign oEND       = end_q;
    assign oX_POS     = x_q;
    assign oY_POS     = y_q;
    assign oFRAME_CNT = cnt_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oERR       = err_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench: each scenario queues the pulses it expects (kind, cycle,
// frame count); a negedge monitor pops and compares every observed pulse.
module tb_capture_sequencer;
    import capture_sequencer_pkg::*;

    localparam int CW = 4;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iFVAL = 1'b0;
    logic          iCMD_VALID = 1'b0;
    logic [1:0]    iCMD_OP = OP_NOP;
    logic [15:0]   iCMD_X = '0;
    logic [15:0]   iCMD_Y = '0;
    logic [CW-1:0] iCMD_N = '0;
    logic          oCMD_READY, oSTART, oEND, oBUSY, oDONE, oERR;
    logic [15:0]   oX_POS, oY_POS;
    logic [CW-1:0] oFRAME_CNT;

    typedef struct { int kind; int cyc; int cnt; } ev_t;   // kind 0=START 1=END 2=DONE
    ev_t  exp_q[$];
    ev_t  mon_e;
    logic [2:0] pulses;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    capture_sequencer #(.CNT_W(CW), .MAX_X(640), .MAX_Y(280), .TIMEOUT(100)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iFVAL(iFVAL), .iCMD_VALID(iCMD_VALID),
        .iCMD_OP(iCMD_OP), .iCMD_X(iCMD_X), .iCMD_Y(iCMD_Y), .iCMD_N(iCMD_N),
        .oCMD_READY(oCMD_READY), .oSTART(oSTART), .oEND(oEND), .oX_POS(oX_POS),
        .oY_POS(oY_POS), .oFRAME_CNT(oFRAME_CNT), .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    always @(negedge iCLK) begin
        pulses = {oDONE, oEND, oSTART};
        for (int k = 0; k < 3; k++) begin
            if (pulses[k] === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pulse_unexpected kind=%0d cyc=%0d cnt=%0d required=none", k, cyc, oFRAME_CNT);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.kind !== k || mon_e.cyc !== cyc || mon_e.cnt !== int'(oFRAME_CNT)) begin
                        bad++;
                        $display("FAIL pulse_match got kind=%0d cyc=%0d cnt=%0d required kind=%0d cyc=%0d cnt=%0d",
                                 k, cyc, oFRAME_CNT, mon_e.kind, mon_e.cyc, mon_e.cnt);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                            input logic [CW-1:0] n);
        iCMD_VALID = 1'b1; iCMD_OP = op; iCMD_X = x; iCMD_Y = y; iCMD_N = n;
        @(negedge iCLK);
        iCMD_VALID = 1'b0; iCMD_OP = OP_NOP;
    endtask

    task automatic push_ev(input int kind, input int at, input int cnt);
        exp_q.push_back(ev_t'{kind, at, cnt});
    endtask

    task automatic end_scenario(input string name);
        tick(3);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got=%0d missing pulses, first kind=%0d cyc=%0d required=0",
                     name, exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
        end
        exp_q.delete();
        total++;
        if (oBUSY !== 1'b0 || oCMD_READY !== 1'b1) begin
            bad++;
            $display("FAIL %s_idle busy=%b ready=%b required busy=0 ready=1", name, oBUSY, oCMD_READY);
        end
    endtask

    task automatic test_reset();
        iRST_N = 1'b0;
        tick(3);
        total++;
        if ({oSTART, oEND, oDONE, oERR, oBUSY} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b required=00000", {oSTART, oEND, oDONE, oERR, oBUSY});
        end
        total++;
        if (oX_POS !== 16'd0 || oY_POS !== 16'd0 || oFRAME_CNT !== '0) begin
            bad++;
            $display("FAIL reset_regs got x=%0d y=%0d cnt=%0d required 0 0 0", oX_POS, oY_POS, oFRAME_CNT);
        end
        iRST_N = 1'b1;
        tick(2);
        total++;
        if (oCMD_READY !== 1'b1 || oBUSY !== 1'b0) begin
            bad++;
            $display("FAIL reset_release ready=%b busy=%b required 1 0", oCMD_READY, oBUSY);
        end
    endtask

    task automatic test_set_win();
        logic [15:0] xs [3] = '{16'd800, 16'd10,  16'd640};
        logic [15:0] ys [3] = '{16'd100, 16'd300, 16'd280};
        logic [15:0] ex [3] = '{16'd640, 16'd10,  16'd640};
        logic [15:0] ey [3] = '{16'd100, 16'd280, 16'd280};
        for (int i = 0; i < 3; i++) begin
            send_cmd(OP_SET_WIN, xs[i], ys[i], '0);
            total++;
            if (oX_POS !== ex[i] || oY_POS !== ey[i] || oBUSY !== 1'b0) begin
                bad++;
                $display("FAIL set_win%0d got x=%0d y=%0d busy=%b required x=%0d y=%0d busy=0",
                         i, oX_POS, oY_POS, oBUSY, ex[i], ey[i]);
            end
        end
        end_scenario("set_win");
    endtask

    task automatic test_snap3();
        int f;
        iFVAL = 1'b0;
        push_ev(0, cyc + 2, 0);
        send_cmd(OP_SNAP, '0, '0, 4'd3);
        tick(1);
        for (f = 1; f <= 5; f++) begin
            if (f == 3) push_ev(1, cyc + 1, 3);
            iFVAL = 1'b1;
            tick(3);
            total++;
            if (int'(oFRAME_CNT) !== ((f < 3) ? f : 3)) begin
                bad++;
                $display("FAIL snap3_cnt frame=%0d got=%0d required=%0d", f, oFRAME_CNT, (f < 3) ? f : 3);
            end
            if (f == 3) push_ev(2, cyc + 1, 3);
            iFVAL = 1'b0;
            tick(3);
        end
        end_scenario("snap3");
    endtask

    task automatic test_midframe();
        iFVAL = 1'b1;
        tick(2);
        send_cmd(OP_SNAP, '0, '0, 4'd1);
        tick(3);
        push_ev(0, cyc + 1, 0);
        iFVAL = 1'b0;
        tick(2);
        push_ev(1, cyc + 1, 1);
        iFVAL = 1'b1;
        tick(3);
        push_ev(2, cyc + 1, 1);
        iFVAL = 1'b0;
        tick(2);
        total++;
        if (oFRAME_CNT !== 4'd1) begin
            bad++;
            $display("FAIL midframe_cnt got=%0d required=1", oFRAME_CNT);
        end
        end_scenario("midframe");
    endtask

    task automatic test_continuous_stop();
        iFVAL = 1'b0;
        push_ev(0, cyc + 2, 0);
        send_cmd(OP_SNAP, '0, '0, 4'd0);
        tick(1);
        for (int f = 1; f <= 3; f++) begin
            iFVAL = 1'b1; tick(3);
            iFVAL = 1'b0; tick(3);
        end
        iFVAL = 1'b1;
        tick(2);
        push_ev(1, cyc + 1, 4);
        send_cmd(OP_STOP, '0, '0, '0);
        push_ev(2, cyc + 1, 4);
        iFVAL = 1'b0;
        tick(2);
        total++;
        if (oFRAME_CNT !== 4'd4) begin
            bad++;
            $display("FAIL cont_stop_cnt got=%0d required=4", oFRAME_CNT);
        end
        end_scenario("cont_stop");
    endtask

    task automatic test_wrap();
        iFVAL = 1'b0;
        push_ev(0, cyc + 2, 0);
        send_cmd(OP_SNAP, '0, '0, 4'd0);
        tick(1);
        for (int f = 1; f <= 17; f++) begin
            iFVAL = 1'b1; tick(2);
            iFVAL = 1'b0; tick(2);
        end
        total++;
        if (oFRAME_CNT !== 4'd1 || oBUSY !== 1'b1) begin
            bad++;
            $display("FAIL wrap_cnt got cnt=%0d busy=%b required cnt=1 busy=1", oFRAME_CNT, oBUSY);
        end
        push_ev(1, cyc + 1, 1);
        send_cmd(OP_STOP, '0, '0, '0);
        iFVAL = 1'b1; tick(2);
        push_ev(2, cyc + 1, 1);
        iFVAL = 1'b0;
        end_scenario("wrap");
    endtask

    task automatic test_back_to_back();
        iFVAL = 1'b0;
        push_ev(0, cyc + 2, 0);
        send_cmd(OP_SNAP, '0, '0, 4'd5);
        tick(1);
        push_ev(1, cyc + 1, 1);
        iFVAL = 1'b1;
        send_cmd(OP_STOP, '0, '0, '0);
        tick(2);
        push_ev(2, cyc + 1, 1);
        iFVAL = 1'b0;
        end_scenario("stop_rise");
    endtask

    task automatic test_stop_sync();
        iFVAL = 1'b1;
        tick(1);
        send_cmd(OP_SNAP, '0, '0, 4'd2);
        send_cmd(OP_SET_WIN, 16'd5, 16'd5, '0);
        send_cmd(OP_STOP, '0, '0, '0);
        total++;
        if (oX_POS !== 16'd640 || oY_POS !== 16'd280) begin
            bad++;
            $display("FAIL stop_sync_win got x=%0d y=%0d required x=640 y=280", oX_POS, oY_POS);
        end
        iFVAL = 1'b0;
        end_scenario("stop_sync");
    endtask

    task automatic test_stop_armed();
        iFVAL = 1'b0;
        push_ev(0, cyc + 2, 0);
        send_cmd(OP_SNAP, '0, '0, 4'd2);
        tick(1);
        push_ev(1, cyc + 1, 0);
        send_cmd(OP_STOP, '0, '0, '0);
        end_scenario("stop_armed");
    endtask

    task automatic test_timeout();
        int t0;
        iFVAL = 1'b0;
        push_ev(0, cyc + 2, 0);
        send_cmd(OP_SNAP, '0, '0, 4'd2);
        tick(1);
        t0 = cyc;
        push_ev(1, t0 + 100, 0);
        tick(99);
        total++;
        if (oERR !== 1'b0 || oBUSY !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early err=%b busy=%b required err=0 busy=1", oERR, oBUSY);
        end
        tick(1);
        total++;
        if (oERR !== 1'b1 || oBUSY !== 1'b0) begin
            bad++;
            $display("FAIL timeout_fire err=%b busy=%b required err=1 busy=0", oERR, oBUSY);
        end
        end_scenario("timeout");
        total++;
        if (oERR !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky err=%b required=1", oERR);
        end
    endtask

    task automatic test_reset_mid();
        iFVAL = 1'b0;
        push_ev(0, cyc + 2, 0);
        send_cmd(OP_SNAP, '0, '0, 4'd0);
        tick(1);
        total++;
        if (oERR !== 1'b0) begin
            bad++;
            $display("FAIL snap_clears_err got=%b required=0", oERR);
        end
        iFVAL = 1'b1;
        tick(2);
        total++;
        if (oFRAME_CNT !== 4'd1 || oBUSY !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre cnt=%0d busy=%b required cnt=1 busy=1", oFRAME_CNT, oBUSY);
        end
        #2 iRST_N = 1'b0;
        #1;
        total++;
        if ({oSTART, oEND, oDONE, oERR, oBUSY} !== 5'b0 || oFRAME_CNT !== '0 || oX_POS !== 16'd0 ||
            oY_POS !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid_async flags=%b cnt=%0d x=%0d y=%0d required 00000 0 0 0",
                     {oSTART, oEND, oDONE, oERR, oBUSY}, oFRAME_CNT, oX_POS, oY_POS);
        end
        tick(1);
        iRST_N = 1'b1;
        tick(2);
        iFVAL = 1'b0; tick(3);
        iFVAL = 1'b1; tick(3);
        iFVAL = 1'b0;
        end_scenario("reset_mid");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_set_win();
        test_snap3();
        test_midframe();
        test_continuous_stop();
        test_wrap();
        test_back_to_back();
        test_stop_sync();
        test_stop_armed();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter CNT_W, default 16: width of the frame-count request and frame counter.
REQ-002 Parameter MAX_X, default 640: largest legal window X origin; SET_WIN clamps to it.
REQ-003 Parameter MAX_Y, default 280: largest legal window Y origin; SET_WIN clamps to it.
REQ-004 Parameter TIMEOUT, default 2^24: watchdog limit, in clocks without an iFVAL edge.
REQ-005 iCLK  in  1  sensor pixel clock, all logic rising-edge.
REQ-006 iRST_N  in  1  reset, asynchronous, active-low.
REQ-007 iFVAL  in  1  sensor frame-valid, synchronous to iCLK.
REQ-008 iCMD_VALID  in  1  command strobe; accepted when iCMD_VALID and oCMD_READY are both high.
REQ-009 iCMD_OP  in  2  0=NOP, 1=SNAP, 2=STOP, 3=SET_WIN.
REQ-010 iCMD_X, iCMD_Y  in  16 each  window origin for SET_WIN.
REQ-011 iCMD_N  in  CNT_W  frames for SNAP; 0 means continuous.
REQ-012 oCMD_READY  out  1  high in IDLE; STOP is also accepted in every other state.
REQ-013 oSTART, oEND  out  1 each  single-cycle pulses to the capture datapath's start/end inputs.
REQ-014 oX_POS, oY_POS  out  16 each  registered window origin driven to the capture datapath.
REQ-015 oFRAME_CNT  out  CNT_W  frames started in the current SNAP.
REQ-016 oBUSY  out  1  high in any state except IDLE.
REQ-017 oDONE  out  1  single-cycle pulse on normal completion.
REQ-018 oERR  out  1  sticky watchdog flag.

Function
REQ-019 iFVAL is registered once (pFVAL) for edge detection: rise = {pFVAL,iFVAL}==01, fall = 10.
REQ-020 States: IDLE, SYNC, ARMED, RUN, DRAIN; encoding is registered, one-hot or binary.
REQ-021 IDLE, SNAP accepted: load N, clear oFRAME_CNT and oERR, go to SYNC.
REQ-022 IDLE, SET_WIN accepted: oX_POS = min(iCMD_X, MAX_X), oY_POS = min(iCMD_Y, MAX_Y), effective next cycle; state stays IDLE.
REQ-023 SET_WIN and SNAP are ignored (not accepted) outside IDLE; the window never changes while oBUSY is high.
REQ-024 NOP is accepted and has no effect.
REQ-025 SYNC: wait until iFVAL=0 (never arm mid-frame); then pulse oSTART for one cycle and go to ARMED.
REQ-026 ARMED, rise: oFRAME_CNT+1. If N=1, pulse oEND on the next cycle and go to DRAIN; otherwise go to RUN.
REQ-027 RUN, rise: oFRAME_CNT+1. When the new count equals N (N≠0), pulse oEND on the next cycle and go to DRAIN.
REQ-028 N=0 (continuous): stay in RUN; oFRAME_CNT wraps modulo 2^CNT_W with no other effect.
REQ-029 DRAIN, fall: pulse oDONE and go to IDLE.
REQ-030 STOP accepted in SYNC: go to IDLE; no oSTART, oEND or oDONE.
REQ-031 STOP accepted in ARMED: pulse oEND, go to IDLE, no oDONE.
REQ-032 STOP accepted in RUN: pulse oEND, go to DRAIN.
REQ-033 STOP accepted in DRAIN: ignored.
REQ-034 STOP and a rise in the same cycle: the rise is counted first, then STOP applies; exactly one oEND pulse.
REQ-035 Watchdog counter clears on any iFVAL edge and on every state change; it counts while oBUSY is high.
REQ-036 Watchdog reaching TIMEOUT: pulse oEND if in ARMED or RUN, set oERR, go to IDLE, no oDONE.
REQ-037 oSTART and oEND are never high in the same cycle; each pulse is exactly one clock wide.
REQ-038 All outputs are registered.

Reset
REQ-039 iRST_N low: state=IDLE; oX_POS=0; oY_POS=0; oFRAME_CNT=0; oSTART=0; oEND=0; oDONE=0; oERR=0; oBUSY=0; pFVAL=0; watchdog=0.
REQ-040 Reset mid-capture: no oEND is issued; after reset the capture datapath is rearmed only by a new SNAP.

Structure
REQ-041 A shared package holds the command opcode constants (OP_NOP, OP_SNAP, OP_STOP, OP_SET_WIN) and the state encoding.
REQ-042 One sub-module, fval_edge: register plus rise/fall detect. The watchdog stays inline.

Verification
REQ-043 SET_WIN X=800, Y=100 in IDLE -> oX_POS=640, oY_POS=100 one cycle later.
REQ-044 SNAP N=3, iFVAL starting low, 5 frames driven -> one oSTART; oFRAME_CNT reaches 3; oEND one cycle after the 3rd rise; oDONE at the 3rd fall; frames 4-5 not counted.
REQ-045 SNAP N=1 issued mid-frame (iFVAL=1) -> oSTART only after that frame's fall; the next frame is counted; oDONE at its fall.
REQ-046 SNAP N=0, 4 frames, then STOP during frame 4 -> oEND the cycle after STOP; oDONE at frame 4's fall; oFRAME_CNT=4.
REQ-047 SNAP with TIMEOUT=100 and iFVAL held low -> oEND and oERR set at cycle 100 of ARMED; state returns to IDLE; oDONE stays low.
REQ-048 iRST_N asserted in RUN -> all outputs at reset values immediately; no pulses after release.
